// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_pkg
//  Purpose  : Shared types for the dataslot command path arbiter: the
//             arbiter state encoding, the latched command record and the
//             result code reported when the host never answers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bridge_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_e;

   localparam logic [7:0] RESULT_TIMEOUT = 8'hFF;

   typedef struct packed {
      logic        write;
      logic [15:0] slot_id;
      logic [31:0] slot_offset;
      logic [31:0] bridge_addr;
      logic [31:0] length;
   } dataslot_cmd_t;

   // Index width for a client count; a single client still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_dataslot_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: first set request bit at or
//             after the pointer, wrapping around the client count.
//  Ports    : req        in   NUM_CLIENTS  request vector
//             ptr        in   IDX_W        highest-priority client index
//             grant      out  NUM_CLIENTS  one-hot winner (zero if none)
//             grant_idx  out  IDX_W        winner index (zero if none)
//             any        out  1            at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import bridge_pkg::*;
#(
   parameter int NUM_CLIENTS = 4,
   parameter int IDX_W       = idx_width(NUM_CLIENTS)
) (
   input  logic [NUM_CLIENTS-1:0] req,
   input  logic [IDX_W-1:0]       ptr,
   output logic [NUM_CLIENTS-1:0] grant,
   output logic [IDX_W-1:0]       grant_idx,
   output logic                   any
);

   logic [IDX_W-1:0] cand;

   // Walk the clients starting at the pointer; the first hit wins and
   // later hits are masked by 'any'.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_CLIENTS);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bridge_dataslot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_dataslot_arbiter
//  Purpose  : Shares the single dataslot read/write request engine between
//             NUM_CLIENTS core-side requesters. Round-robin grant, latched
//             command, valid/ready issue, wait for completion or timeout,
//             then a one-cycle done pulse with result to the winner only.
//  Ports    : clk, reset_n                 clock, async active-low reset
//             cli_valid/write/slot_id/slot_offset/bridge_addr/length  in
//             cli_done (one-hot pulse), cli_result              out
//             req_valid, req_write, req_slot_id, req_slot_offset,
//             req_bridge_addr, req_length                       out
//             req_ready, resp_done, resp_result                 in
//             busy                                              out
//  Revision : 1.0 - initial release
// ============================================================================
module bridge_dataslot_arbiter
   import bridge_pkg::*;
#(
   parameter int          NUM_CLIENTS    = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_CLIENTS-1:0]    cli_valid,
   input  logic [NUM_CLIENTS-1:0]    cli_write,
   input  logic [NUM_CLIENTS*16-1:0] cli_slot_id,
   input  logic [NUM_CLIENTS*32-1:0] cli_slot_offset,
   input  logic [NUM_CLIENTS*32-1:0] cli_bridge_addr,
   input  logic [NUM_CLIENTS*32-1:0] cli_length,
   output logic [NUM_CLIENTS-1:0]    cli_done,
   output logic [7:0]                cli_result,
   output logic                      req_valid,
   input  logic                      req_ready,
   output logic                      req_write,
   output logic [15:0]               req_slot_id,
   output logic [31:0]               req_slot_offset,
   output logic [31:0]               req_bridge_addr,
   output logic [31:0]               req_length,
   input  logic                      resp_done,
   input  logic [7:0]                resp_result,
   output logic                      busy
);

   localparam int IDX_W = idx_width(NUM_CLIENTS);

   arb_state_e             state, state_nx;
   dataslot_cmd_t          cmd, cmd_nx, sel_cmd;
   logic [IDX_W-1:0]       grant_idx, grant_idx_nx, rr_ptr, rr_ptr_nx, arb_idx;
   logic [NUM_CLIENTS-1:0] grant_oh, grant_oh_nx, arb_grant, done_nx;
   logic                   arb_any;
   logic [31:0]            tmo_cnt, tmo_cnt_nx;
   logic [7:0]             result_nx;
   logic                   req_valid_nx, busy_nx;

   rr_arbiter #(
      .NUM_CLIENTS (NUM_CLIENTS),
      .IDX_W       (IDX_W)
   ) u_rr (
      .req       (cli_valid),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   // Fields of the current arbitration winner, captured only in IDLE.
   always_comb begin
      sel_cmd.write       = cli_write[arb_idx];
      sel_cmd.slot_id     = cli_slot_id[int'(arb_idx)*16 +: 16];
      sel_cmd.slot_offset = cli_slot_offset[int'(arb_idx)*32 +: 32];
      sel_cmd.bridge_addr = cli_bridge_addr[int'(arb_idx)*32 +: 32];
      sel_cmd.length      = cli_length[int'(arb_idx)*32 +: 32];
   end

   always_comb begin
      state_nx     = state;
      cmd_nx       = cmd;
      grant_idx_nx = grant_idx;
      grant_oh_nx  = grant_oh;
      rr_ptr_nx    = rr_ptr;
      tmo_cnt_nx   = tmo_cnt;
      req_valid_nx = 1'b0;
      done_nx      = '0;
      result_nx    = 8'h00;
      case (state)
         ARB_IDLE: begin
            if (arb_any) begin
               state_nx     = ARB_ISSUE;
               cmd_nx       = sel_cmd;
               grant_idx_nx = arb_idx;
               grant_oh_nx  = arb_grant;
               req_valid_nx = 1'b1;
            end
         end
         ARB_ISSUE: begin
            req_valid_nx = 1'b1;
            if (req_valid && req_ready) begin
               state_nx     = ARB_WAIT;
               tmo_cnt_nx   = '0;
               req_valid_nx = 1'b0;
            end
         end
         ARB_WAIT: begin
            // A real completion beats a timeout expiring in the same cycle.
            if (resp_done) begin
               state_nx  = ARB_RESP;
               done_nx   = grant_oh;
               result_nx = resp_result;
            end else if ((TIMEOUT_CYCLES != 32'd0) &&
                         (tmo_cnt == TIMEOUT_CYCLES - 32'd1)) begin
               state_nx  = ARB_RESP;
               done_nx   = grant_oh;
               result_nx = RESULT_TIMEOUT;
            end else if (tmo_cnt != '1) begin
               tmo_cnt_nx = tmo_cnt + 32'd1;
            end
         end
         ARB_RESP: begin
            state_nx  = ARB_IDLE;
            rr_ptr_nx = (grant_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0
                                                               : grant_idx + 1'b1;
         end
         default: state_nx = ARB_IDLE;
      endcase
      busy_nx = (state_nx != ARB_IDLE);
   end

   // Every output is a flop loaded from the next-state logic above.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ARB_IDLE;
         cmd        <= '0;
         grant_idx  <= '0;
         grant_oh   <= '0;
         rr_ptr     <= '0;
         tmo_cnt    <= '0;
         req_valid  <= 1'b0;
         cli_done   <= '0;
         cli_result <= 8'h00;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         cmd        <= cmd_nx;
         grant_idx  <= grant_idx_nx;
         grant_oh   <= grant_oh_nx;
         rr_ptr     <= rr_ptr_nx;
         tmo_cnt    <= tmo_cnt_nx;
         req_valid  <= req_valid_nx;
         cli_done   <= done_nx;
         cli_result <= result_nx;
         busy       <= busy_nx;
      end
   end

   assign req_write       = cmd.write;
   assign req_slot_id     = cmd.slot_id;
   assign req_slot_offset = cmd.slot_offset;
   assign req_bridge_addr = cmd.bridge_addr;
   assign req_length      = cmd.length;

endmodule
`default_nettype wire

// File: doc/bridge_dataslot_arbiter.md
# bridge_dataslot_arbiter

Shares the single core-to-host dataslot command path (core_dataslot_read / core_dataslot_write request engine) between up to NUM_CLIENTS core-side requesters. Arbitrates round-robin, latches the winner's command, issues it downstream with a valid/ready handshake, and waits for completion or timeout. Returns the host result to the winning client only. Sits between core logic (loaders, save managers) and the bridge request engine.

## Interface
- NUM_CLIENTS, 4: number of requesters, 1..8.
- TIMEOUT_CYCLES, 32'd50_000_000: cycles to wait for resp_done before aborting; 0 disables the timeout.
- clk  in  1  bridge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- cli_valid  in  NUM_CLIENTS  per-client request; held high until that client's cli_done.
- cli_write  in  NUM_CLIENTS  per-client op: 0 = read, 1 = write.
- cli_slot_id  in  NUM_CLIENTS x 16  dataslot id.
- cli_slot_offset  in  NUM_CLIENTS x 32  byte offset in slot.
- cli_bridge_addr  in  NUM_CLIENTS x 32  bridge address of the data.
- cli_length  in  NUM_CLIENTS x 32  byte count.
- cli_done  out  NUM_CLIENTS  one-cycle completion pulse, one-hot.
- cli_result  out  8  result code; valid while any cli_done is high.
- req_valid  out  1  command to the request engine.
- req_ready  in  1  request engine accepts command.
- req_write, req_slot_id, req_slot_offset, req_bridge_addr, req_length  out  1/16/32/32/32  latched command fields.
- resp_done  in  1  one-cycle completion pulse from the request engine.
- resp_result  in  8  host result, valid with resp_done.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any cli_valid, pick the first set bit at or after rr_ptr (wrapping); register grant index and all its fields; go to ISSUE.
- ISSUE: req_valid = 1, fields stable. On req_valid && req_ready go to WAIT, clear timeout counter.
- WAIT: on resp_done latch resp_result, go to RESP. Otherwise increment counter; when TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES - 1, latch result RESULT_TIMEOUT, go to RESP.
- RESP: cli_done[grant] = 1 for one cycle with cli_result; rr_ptr = (grant + 1) mod NUM_CLIENTS; go to IDLE.
- Exactly one command outstanding at a time.
- A client dropping cli_valid after grant does not cancel; its command completes and cli_done still pulses.
- Changes to a granted client's fields after grant are ignored.
- resp_done outside WAIT is ignored; resp_done in the same cycle as timeout expiry: resp_done wins, real result returned.
- Timeout counter is 32 bit, saturating, never wraps.
- Clients not granted see no change; their valid stays pending.

## Timing
- Reset (async assert, sync release): state IDLE, rr_ptr 0, all outputs 0 (req_valid, cli_done, cli_result, busy, all req_* fields).
- Reset mid-transaction aborts with no cli_done pulse; the client must re-request.
- cli_valid rise in cycle N -> req_valid high in N+1 (if IDLE).
- req_ready accept in cycle N -> WAIT from N+1.
- resp_done in cycle N -> cli_done in N+1 -> IDLE in N+2; next grant earliest N+2, req_valid N+3.
- Minimum turnaround per command: 4 cycles with req_ready and resp_done both immediate.
- All outputs registered.

## Structure
- bridge_pkg gains: arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}; localparam RESULT_TIMEOUT = 8'hFF; dataslot_cmd_t struct {write, slot_id, slot_offset, bridge_addr, length}.
- One sub-module: rr_arbiter (NUM_CLIENTS request vector + pointer -> one-hot grant + index, combinational).

## Test plan
- Single client 0, read, slot 16'h0003, offset 0, length 32'h200, req_ready tied high, resp_done 2 cycles after accept with result 8'h00 -> req fields match, cli_done[0] once with cli_result 8'h00, busy low afterwards.
- Clients 0, 1, 3 all valid continuously -> grant order 0, 1, 3, 0 with rr_ptr wrap; never two outstanding commands.
- TIMEOUT_CYCLES = 10, resp_done never asserted -> cli_done for the granted client 11 cycles after accept with cli_result 8'hFF; a late resp_done in IDLE is ignored.
- resp_done in the exact expiry cycle with result 8'h02 -> cli_result 8'h02, not 8'hFF.
- req_ready held low 20 cycles while client fields change -> req_* stay at the values latched at grant; accept on cycle 21.
- reset_n pulsed low during WAIT -> all outputs 0 immediately, no cli_done, next request restarts from client 0.
